// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg
//   Shared definitions for the accumulator memory controller:
//     - acc_state_e : controller FSM states (IDLE, RUN, DRAIN, DONE)
//     - ACC_WIDTH_DEF / ACCUM_ROW_DEF / ADDR_WIDTH_DEF : default widths
//     - stage_t     : one per-column pipeline slot (valid, addr, psum)
//     - acc_add()   : read-modify-write adder
//   Build option: ACCUM_SAT_EN
//     defined   -> acc_add saturates to the signed max/min on overflow
//     undefined -> acc_add wraps modulo 2^ACC_WIDTH
//   stage_t and acc_add are sized from the *_DEF constants, so a width change
//   is made here and the top-level parameters follow the same values.
// ---------------------------------------------------------------------------
package accum_pkg;

    localparam int ACC_WIDTH_DEF  = 32;
    localparam int ACCUM_ROW_DEF  = 128;
    localparam int ADDR_WIDTH_DEF = $clog2(ACCUM_ROW_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

    typedef struct packed {
        logic                      valid;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [ACC_WIDTH_DEF-1:0]  psum;
    } stage_t;

    function automatic logic [ACC_WIDTH_DEF-1:0] acc_add(
        input logic [ACC_WIDTH_DEF-1:0] a,
        input logic [ACC_WIDTH_DEF-1:0] b
    );
        logic [ACC_WIDTH_DEF-1:0] s;
        s = a + b;
`ifdef ACCUM_SAT_EN
        // Signed overflow: operands share a sign that the result lost.
        if ((a[ACC_WIDTH_DEF-1] == b[ACC_WIDTH_DEF-1]) &&
            (s[ACC_WIDTH_DEF-1] != a[ACC_WIDTH_DEF-1])) begin
            s = a[ACC_WIDTH_DEF-1] ? {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
        end
`endif
        return s;
    endfunction

endpackage

// File: rtl/accum_col_pipe.sv
// ---------------------------------------------------------------------------
// accum_col_pipe
//   One accumulator column: row counter plus a 3-stage read-modify-write
//   pipeline toward one accumulator SRAM bank.
//     S1: register read request (rd_en/rd_addr) and the psum
//     S2: bank returns rd_data; sum = overwrite ? psum : rd_data + psum
//     S3: register the write (wr_en/wr_addr/wr_data)
//   Ports:
//     clk, rstn           clock, asynchronous active-low reset
//     clear               clear the row counter (tile accepted)
//     run                 accept valids (controller in RUN)
//     track               flag valids that find the column full
//     overwrite           tile mode, stable for the whole tile
//     num_row             clamped rows for this tile
//     psum_valid/psum_in  column result from the array
//     rd_data             bank read data, one cycle after rd_en
//     rd_en/rd_addr       bank read port
//     wr_en/wr_addr/wr_data bank write port
//     full                counter has reached num_row
//     s1_busy             an entry sits in S1
//     ovf                 a valid arrived while full (combinational)
// ---------------------------------------------------------------------------
module accum_col_pipe
    import accum_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic                      run,
    input  logic                      track,
    input  logic                      overwrite,
    input  logic [ADDR_WIDTH_DEF:0]   num_row,
    input  logic                      psum_valid,
    input  logic [ACC_WIDTH_DEF-1:0]  psum_in,
    input  logic [ACC_WIDTH_DEF-1:0]  rd_data,
    output logic                      rd_en,
    output logic [ADDR_WIDTH_DEF-1:0] rd_addr,
    output logic                      wr_en,
    output logic [ADDR_WIDTH_DEF-1:0] wr_addr,
    output logic [ACC_WIDTH_DEF-1:0]  wr_data,
    output logic                      full,
    output logic                      s1_busy,
    output logic                      ovf
);

    logic [ADDR_WIDTH_DEF:0]   cnt_reg;
    stage_t                    s1_reg;
    stage_t                    s2_reg;
    logic                      rd_en_reg;
    logic                      wr_en_reg;
    logic [ADDR_WIDTH_DEF-1:0] wr_addr_reg;
    logic [ACC_WIDTH_DEF-1:0]  wr_data_reg;
    logic                      accept;
    logic [ACC_WIDTH_DEF-1:0]  sum;

    assign full    = (cnt_reg >= num_row);
    assign accept  = run && psum_valid && !full;
    assign ovf     = track && psum_valid && full;
    assign s1_busy = s1_reg.valid;

    // rd_data pairs with the entry now in S2 (read was issued from S1).
    assign sum = overwrite ? s2_reg.psum : acc_add(rd_data, s2_reg.psum);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg     <= '0;
            s1_reg      <= '0;
            s2_reg      <= '0;
            rd_en_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            if (clear) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // S1: the address flows even in overwrite mode; only the read is
            // suppressed.
            s1_reg.valid <= accept;
            rd_en_reg    <= accept && !overwrite;
            if (accept) begin
                s1_reg.addr <= cnt_reg[ADDR_WIDTH_DEF-1:0];
                s1_reg.psum <= psum_in;
            end

            // S2
            s2_reg <= s1_reg;

            // S3
            wr_en_reg <= s2_reg.valid;
            if (s2_reg.valid) begin
                wr_addr_reg <= s2_reg.addr;
                wr_data_reg <= sum;
            end
        end
    end

    assign rd_en   = rd_en_reg;
    assign rd_addr = s1_reg.addr;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: rtl/accum_mem_ctrl.sv
// ---------------------------------------------------------------------------
// accum_mem_ctrl
//   Collects column-skewed partial sums from the systolic array bottom edge
//   and accumulates them into SYS_COL accumulator banks (read-modify-write,
//   or plain store on the first K-tile). Signals completion once every column
//   has written num_row rows.
//   Ports:
//     clk, rstn            clock, asynchronous active-low reset
//     acc_start            one-cycle pulse, begins a tile (ignored unless IDLE)
//     overwrite, num_row   tile mode and row count, sampled with acc_start
//     psum_valid, psum_in  per-column results (skewed one cycle per column)
//     rd_en/rd_addr        bank read ports, rd_data returns one cycle later
//     wr_en/wr_addr/wr_data bank write ports
//     acc_busy             tile in progress
//     acc_done             one-cycle completion pulse
//     ovf_err              sticky: valid seen on an already-full column
//   Saturating accumulation is selected with ACCUM_SAT_EN (see accum_pkg).
// ---------------------------------------------------------------------------
module accum_mem_ctrl
    import accum_pkg::*;
#(
    parameter  int SYS_COL    = 16,
    parameter  int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter  int ACCUM_ROW  = ACCUM_ROW_DEF,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  acc_start,
    input  logic                  overwrite,
    input  logic [ADDR_WIDTH:0]   num_row,
    input  logic [SYS_COL-1:0]    psum_valid,
    input  logic [ACC_WIDTH-1:0]  psum_in [0:SYS_COL-1],
    output logic [SYS_COL-1:0]    rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr [0:SYS_COL-1],
    input  logic [ACC_WIDTH-1:0]  rd_data [0:SYS_COL-1],
    output logic [SYS_COL-1:0]    wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_COL-1],
    output logic [ACC_WIDTH-1:0]  wr_data [0:SYS_COL-1],
    output logic                  acc_busy,
    output logic                  acc_done,
    output logic                  ovf_err
);

    localparam logic [ADDR_WIDTH:0] ROW_MAX = (ADDR_WIDTH+1)'(ACCUM_ROW);

    acc_state_e          state_reg;
    logic                overwrite_reg;
    logic [ADDR_WIDTH:0] num_row_reg;
    logic                acc_busy_reg;
    logic                acc_done_reg;
    logic                ovf_err_reg;

    logic [ADDR_WIDTH:0] num_row_clamped;
    logic                start_accept;
    logic                run_en;
    logic                track_en;
    logic [SYS_COL-1:0]  col_full;
    logic [SYS_COL-1:0]  col_s1_busy;
    logic [SYS_COL-1:0]  col_ovf;

    assign num_row_clamped = (num_row > ROW_MAX) ? ROW_MAX : num_row;
    assign start_accept    = (state_reg == IDLE) && acc_start;
    assign run_en          = (state_reg == RUN);
    // Late valids in DRAIN are still errors; in IDLE/DONE they are ignored.
    assign track_en        = (state_reg == RUN) || (state_reg == DRAIN);

    for (genvar gi = 0; gi < SYS_COL; gi++) begin : g_col
        accum_col_pipe u_col (
            .clk        (clk),
            .rstn       (rstn),
            .clear      (start_accept),
            .run        (run_en),
            .track      (track_en),
            .overwrite  (overwrite_reg),
            .num_row    (num_row_reg),
            .psum_valid (psum_valid[gi]),
            .psum_in    (psum_in[gi]),
            .rd_data    (rd_data[gi]),
            .rd_en      (rd_en[gi]),
            .rd_addr    (rd_addr[gi]),
            .wr_en      (wr_en[gi]),
            .wr_addr    (wr_addr[gi]),
            .wr_data    (wr_data[gi]),
            .full       (col_full[gi]),
            .s1_busy    (col_s1_busy[gi]),
            .ovf        (col_ovf[gi])
        );
    end

    // Timeline for a tile whose last accept happens at cycle t:
    //   t+1 RUN sees every column full -> DRAIN at t+2
    //   t+2 S1 is empty (S2 holds the last entry, moving to S3) -> DONE at t+3
    //   t+3 last write issued while in DONE
    //   t+4 acc_done pulse, one cycle after the final write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            overwrite_reg <= 1'b0;
            num_row_reg   <= '0;
            acc_busy_reg  <= 1'b0;
            acc_done_reg  <= 1'b0;
            ovf_err_reg   <= 1'b0;
        end else begin
            acc_done_reg <= 1'b0;
            if (|col_ovf) begin
                ovf_err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (acc_start) begin
                        overwrite_reg <= overwrite;
                        num_row_reg   <= num_row_clamped;
                        ovf_err_reg   <= 1'b0;
                        acc_busy_reg  <= 1'b1;
                        state_reg     <= (num_row_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (&col_full) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!(|col_s1_busy)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    acc_done_reg <= 1'b1;
                    acc_busy_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign acc_busy = acc_busy_reg;
    assign acc_done = acc_done_reg;
    assign ovf_err  = ovf_err_reg;

endmodule

// File: tb/tb_accum_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accum_mem_ctrl
//   Directed bench for accum_mem_ctrl with a behavioural bank model
//   (registered read, one cycle latency) and hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_accum_mem_ctrl;

    localparam int SYS_COL    = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int ACCUM_ROW  = 128;
    localparam int ADDR_WIDTH = 7;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b1;
    logic                  acc_start = 1'b0;
    logic                  overwrite = 1'b0;
    logic [ADDR_WIDTH:0]   num_row = '0;
    logic [SYS_COL-1:0]    psum_valid = '0;
    logic [ACC_WIDTH-1:0]  psum_in [0:SYS_COL-1];
    logic [SYS_COL-1:0]    rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr [0:SYS_COL-1];
    logic [ACC_WIDTH-1:0]  rd_data [0:SYS_COL-1];
    logic [SYS_COL-1:0]    wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_COL-1];
    logic [ACC_WIDTH-1:0]  wr_data [0:SYS_COL-1];
    logic                  acc_busy;
    logic                  acc_done;
    logic                  ovf_err;

    accum_mem_ctrl #(
        .SYS_COL   (SYS_COL),
        .ACC_WIDTH (ACC_WIDTH),
        .ACCUM_ROW (ACCUM_ROW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .acc_start  (acc_start),
        .overwrite  (overwrite),
        .num_row    (num_row),
        .psum_valid (psum_valid),
        .psum_in    (psum_in),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .acc_busy   (acc_busy),
        .acc_done   (acc_done),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    // ---------------- bank model ----------------
    logic [ACC_WIDTH-1:0] mem [0:SYS_COL-1][0:ACCUM_ROW-1];
    logic                 init_req = 1'b0;
    int                   init_mode = 0;

    function automatic logic [31:0] init_word(input int c, input int r, input int mode);
        if (mode == 0) return 32'hDEAD0000 | (32'(c) << 8) | 32'(r);
        if (c == 0) return 32'h7FFFFFF0;
        if (c == 1) return 32'h80000005;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < SYS_COL; c++) begin
            if (init_req) begin
                for (int r = 0; r < ACCUM_ROW; r++) mem[c][r] <= init_word(c, r, init_mode);
            end else if (wr_en[c]) begin
                mem[c][wr_addr[c]] <= wr_data[c];
            end
            if (rd_en[c]) rd_data[c] <= mem[c][rd_addr[c]];
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   wr_total = 0, rd_total = 0, done_total = 0, done_cyc = 0;
    int   last_wr_cyc = 0, last_wr_col = 0, rdwr_bad = 0;
    int   wr_cyc_log [0:SYS_COL-1][0:ACCUM_ROW-1];
    logic [7:0] rd_h1 [0:SYS_COL-1];
    logic [7:0] rd_h2 [0:SYS_COL-1];
    logic cur_acc = 1'b0;

    always @(negedge clk) begin
        if (acc_done) begin
            done_total++;
            done_cyc = cyc;
        end
        for (int c = 0; c < SYS_COL; c++) begin
            if (rd_en[c]) rd_total++;
            if (wr_en[c]) begin
                wr_total++;
                wr_cyc_log[c][wr_addr[c]] = cyc;
                last_wr_cyc = cyc;
                last_wr_col = c;
                // accumulate: matching read must have been two cycles earlier
                if (cur_acc && (rd_h2[c] !== {1'b1, wr_addr[c]})) rdwr_bad++;
            end
            rd_h2[c] = rd_h1[c];
            rd_h1[c] = {rd_en[c], rd_addr[c]};
        end
    end

    // ---------------- checking ----------------
    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] bus_or();
        logic [31:0] acc;
        acc = '0;
        for (int c = 0; c < SYS_COL; c++)
            acc = acc | {25'd0, rd_addr[c]} | {25'd0, wr_addr[c]} | wr_data[c];
        return acc;
    endfunction

    function automatic logic [31:0] psum_word(input int c, input int r, input int mode);
        case (mode)
            0: return 32'(r + c);
            1: return 32'd1;
            2: return (c == 0) ? 32'h20 : (c == 1) ? 32'hFFFFFFF0 : 32'd1;
            default: return 32'(r * 3 + c + 100);
        endcase
    endfunction

    function automatic logic [31:0] expect_word(input int c, input int r, input int mode);
        case (mode)
            0: return 32'(r + c);
            1: return 32'(r + c + 1);
            default: return 32'(r * 3 + c + 100);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem(input int mode);
        init_mode = mode;
        init_req  = 1'b1;
        step();
        init_req  = 1'b0;
    endtask

    task automatic start_tile(input logic ov, input logic [7:0] nr, output int s);
        acc_start = 1'b1;
        overwrite = ov;
        num_row   = nr;
        s         = cyc;
        step();
        acc_start = 1'b0;
    endtask

    task automatic drive_rows(input int nr, input int mode, input int extra_col);
        for (int k = 0; k < nr + SYS_COL - 1; k++) begin
            for (int c = 0; c < SYS_COL; c++) begin
                int  r;
                logic v;
                r = k - c;
                v = ((r >= 0) && (r < nr)) || ((c == extra_col) && (r == nr));
                psum_valid[c] = v;
                psum_in[c]    = v ? psum_word(c, r, mode) : 32'h0;
            end
            step();
        end
        psum_valid = '0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        while ((done_total == d0) && (n < 400)) begin
            step();
            n++;
        end
        step();
        step();
        check(tag, 64'(done_total - d0), 64'd1);
    endtask

    task automatic check_rows(input string tag, input int nr, input int mode);
        int errs;
        errs = 0;
        for (int c = 0; c < SYS_COL; c++)
            for (int r = 0; r < nr; r++)
                if (mem[c][r] !== expect_word(c, r, mode)) errs++;
        check(tag, 64'(errs), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, w0, r0, d0, b0;
        for (int c = 0; c < SYS_COL; c++) begin
            psum_in[c] = '0;
            rd_h1[c]   = '0;
            rd_h2[c]   = '0;
        end

        // reset
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 64'({rd_en, wr_en, acc_busy, acc_done, ovf_err}), 64'd0);
        check("rst_bus", 64'(bus_or()), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        step();

        // valids in IDLE are dropped silently
        w0 = wr_total; r0 = rd_total;
        psum_valid = '1;
        step();
        psum_valid = '0;
        repeat (4) step();
        check("idle_valid_ovf", 64'(ovf_err), 64'd0);
        check("idle_valid_mem", 64'((wr_total - w0) + (rd_total - r0)), 64'd0);

        // T1: overwrite tile, num_row=4, psum=row+col
        init_mem(0);
        cur_acc = 1'b0;
        w0 = wr_total; r0 = rd_total; d0 = done_total;
        start_tile(1'b1, 8'd4, s);
        check("t1_busy", 64'(acc_busy), 64'd1);
        drive_rows(4, 0, -1);
        wait_done(d0, "t1_done_once");
        check("t1_done_cyc", 64'(done_cyc), 64'(s + 23));
        check("t1_done_after_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("t1_last_col", 64'(last_wr_col), 64'd15);
        check("t1_lat_col0", 64'(wr_cyc_log[0][0]), 64'(s + 4));
        check("t1_wr_cnt", 64'(wr_total - w0), 64'd64);
        check("t1_rd_cnt", 64'(rd_total - r0), 64'd0);
        check_rows("t1_data", 4, 0);
        check("t1_row4_kept", 64'(mem[6][4]), 64'h00000000DEAD0604);
        check("t1_busy_end", 64'(acc_busy), 64'd0);

        // T2: accumulate tile, psum=1 on top of row+col
        cur_acc = 1'b1;
        w0 = wr_total; r0 = rd_total; d0 = done_total; b0 = rdwr_bad;
        start_tile(1'b0, 8'd4, s);
        drive_rows(4, 1, -1);
        wait_done(d0, "t2_done_once");
        cur_acc = 1'b0;
        check("t2_done_cyc", 64'(done_cyc), 64'(s + 23));
        check("t2_rd_cnt", 64'(rd_total - r0), 64'd64);
        check("t2_wr_cnt", 64'(wr_total - w0), 64'd64);
        check("t2_rd_2_before_wr", 64'(rdwr_bad - b0), 64'd0);
        check_rows("t2_data", 4, 1);
        check("t2_cell_c15r3", 64'(mem[15][3]), 64'd19);

        // T3: fifth valid on column 3 is dropped and flagged
        w0 = wr_total; d0 = done_total;
        start_tile(1'b1, 8'd4, s);
        check("t3_ovf_cleared", 64'(ovf_err), 64'd0);
        drive_rows(4, 0, 3);
        wait_done(d0, "t3_done_once");
        check("t3_ovf_set", 64'(ovf_err), 64'd1);
        check("t3_wr_cnt", 64'(wr_total - w0), 64'd64);
        check("t3_c3r4_kept", 64'(mem[3][4]), 64'h00000000DEAD0304);
        repeat (5) step();
        check("t3_ovf_sticky", 64'(ovf_err), 64'd1);

        // T4: num_row=0 -> done two cycles after start, no memory traffic
        w0 = wr_total; r0 = rd_total; d0 = done_total;
        start_tile(1'b0, 8'd0, s);
        wait_done(d0, "t4_done_once");
        check("t4_done_cyc", 64'(done_cyc), 64'(s + 2));
        check("t4_no_mem", 64'((wr_total - w0) + (rd_total - r0)), 64'd0);
        check("t4_ovf_cleared", 64'(ovf_err), 64'd0);

        // T5: num_row=200 clamps to 128
        w0 = wr_total; d0 = done_total;
        start_tile(1'b1, 8'd200, s);
        drive_rows(128, 0, -1);
        wait_done(d0, "t5_done_once");
        check("t5_wr_cnt", 64'(wr_total - w0), 64'd2048);
        check("t5_done_cyc", 64'(done_cyc), 64'(s + 147));
        check("t5_last_addr_cyc", 64'(wr_cyc_log[15][127]), 64'(s + 146));
        check("t5_cell_c9r127", 64'(mem[9][127]), 64'd136);
        check("t5_ovf", 64'(ovf_err), 64'd0);
        check_rows("t5_data", 128, 0);

        // T6: accumulate overflow behaviour
        init_mem(1);
        d0 = done_total;
        start_tile(1'b0, 8'd1, s);
        drive_rows(1, 2, -1);
        wait_done(d0, "t6_done_once");
`ifdef ACCUM_SAT_EN
        check("t6_pos", 64'(mem[0][0]), 64'h000000007FFFFFFF);
        check("t6_neg", 64'(mem[1][0]), 64'h0000000080000000);
`else
        check("t6_pos", 64'(mem[0][0]), 64'h0000000080000010);
        check("t6_neg", 64'(mem[1][0]), 64'h000000007FFFFFF5);
`endif
        check("t6_plain", 64'(mem[2][0]), 64'd1);

        // T7: reset two rows into an accumulate tile
        w0 = wr_total;
        start_tile(1'b0, 8'd4, s);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < SYS_COL; c++) begin
                psum_valid[c] = (k - c >= 0);
                psum_in[c]    = 32'd5;
            end
            step();
        end
        check("t7_busy_pre", 64'(acc_busy), 64'd1);
        check("t7_rd_pre", 64'(rd_en), 64'h3);
        check("t7_rdaddr_pre", 64'(rd_addr[0]), 64'd1);
        rstn       = 1'b0;
        psum_valid = '0;
        #1;
        check("t7_rst_ctl", 64'({rd_en, wr_en, acc_busy, acc_done, ovf_err}), 64'd0);
        check("t7_rst_bus", 64'(bus_or()), 64'd0);
        repeat (3) step();
        rstn = 1'b1;
        repeat (6) step();
        check("t7_no_wr", 64'(wr_total - w0), 64'd0);
        check("t7_idle", 64'(acc_busy), 64'd0);

        // T8: clean tile after reset
        w0 = wr_total; d0 = done_total;
        start_tile(1'b1, 8'd2, s);
        drive_rows(2, 3, -1);
        wait_done(d0, "t8_done_once");
        check("t8_done_cyc", 64'(done_cyc), 64'(s + 21));
        check("t8_wr_cnt", 64'(wr_total - w0), 64'd32);
        check("t8_cell_c7r1", 64'(mem[7][1]), 64'd110);
        check_rows("t8_data", 2, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
